// File: rtl/pipelined_multiplication_pkg.sv
// Shared helpers for the pipelined multiplier: stage count, product width and
// operand sign/magnitude conversion (operands up to 32 bits).
package pipelined_multiplication_pkg;

    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

    function automatic int unsigned prod_width(input int unsigned width);
        return 2 * width;
    endfunction

    function automatic logic [63:0] low_mask(input int unsigned n);
        return (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
    endfunction

    // Magnitude stays unsigned in `width` bits, so the most negative value maps exactly.
    function automatic logic [63:0] magnitude(input logic [63:0] value, input int unsigned width,
                                              input logic signed_op);
        logic [63:0] v;
        v = value & low_mask(width);
        if (signed_op && v[width-1]) begin
            v = (~v + 64'd1) & low_mask(width);
        end
        return v;
    endfunction

endpackage

// File: rtl/multiplication_stage.sv
// One shift-and-add step: adds multiplicand * low chunk of multiplier, then shifts both.
// Latency 1 enabled edge; no backpressure, enable=0 holds every register.
module multiplication_stage
    import pipelined_multiplication_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_STAGE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 in_vld,
    input  logic                 in_sign,
    input  logic                 in_acc_clr,
    input  logic [2*WIDTH-1:0]   in_mcand,
    input  logic [2*WIDTH-1:0]   in_sum,
    input  logic [WIDTH-1:0]     in_mplier,
    output logic                 out_vld,
    output logic                 out_sign,
    output logic                 out_acc_clr,
    output logic [2*WIDTH-1:0]   out_mcand,
    output logic [2*WIDTH-1:0]   out_sum,
    output logic [WIDTH-1:0]     out_mplier
);

    localparam int PW = prod_width(WIDTH);
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'(low_mask(BITS_PER_STAGE));

    logic          vld_d, vld_q;
    logic          sign_d, sign_q;
    logic          acc_clr_d, acc_clr_q;
    logic [PW-1:0] mcand_d, mcand_q;
    logic [PW-1:0] sum_d, sum_q;
    logic [WIDTH-1:0] mplier_d, mplier_q;

    always_comb begin
        vld_d     = in_vld;
        sign_d    = in_sign;
        acc_clr_d = in_acc_clr;
        sum_d     = in_sum + in_mcand * PW'(in_mplier & CHUNK_MASK);
        mcand_d   = in_mcand << BITS_PER_STAGE;
        mplier_d  = in_mplier >> BITS_PER_STAGE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q     <= 1'b0;
            sign_q    <= 1'b0;
            acc_clr_q <= 1'b0;
            mcand_q   <= '0;
            sum_q     <= '0;
            mplier_q  <= '0;
        end else if (enable) begin
            vld_q     <= vld_d;
            sign_q    <= sign_d;
            acc_clr_q <= acc_clr_d;
            mcand_q   <= mcand_d;
            sum_q     <= sum_d;
            mplier_q  <= mplier_d;
        end
    end

    assign out_vld     = vld_q;
    assign out_sign    = sign_q;
    assign out_acc_clr = acc_clr_q;
    assign out_mcand   = mcand_q;
    assign out_sum     = sum_q;
    assign out_mplier  = mplier_q;

endmodule

// File: rtl/pipelined_multiplication.sv
// Pipelined signed/unsigned shift-and-add multiplier; PIPELINED_MULTIPLICATION_ACCUMULATE_EN adds acc_clear/accumulate.
// Latency STAGES enabled edges (capture edge included); no backpressure, enable=0 freezes all state.
module pipelined_multiplication
    import pipelined_multiplication_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_STAGE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 in_valid,
    input  logic                 signed_mode,
`ifdef PIPELINED_MULTIPLICATION_ACCUMULATE_EN
    input  logic                 acc_clear,
`endif
    input  logic [WIDTH-1:0]     in_1,
    input  logic [WIDTH-1:0]     in_2,
    output logic [2*WIDTH-1:0]   out,
    output logic                 out_valid
);

    localparam int STAGES = ceil_div(WIDTH, BITS_PER_STAGE);
    localparam int PW     = prod_width(WIDTH);
    localparam int LAST   = STAGES - 1;
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'(low_mask(BITS_PER_STAGE));

    // Index 0 is the capture point; index i>0 is the output of registered stage i-1.
    logic [STAGES-1:0]            vld_s;
    logic [STAGES-1:0]            sign_s;
    logic [STAGES-1:0]            acc_clr_s;
    logic [STAGES-1:0][PW-1:0]    mcand_s;
    logic [STAGES-1:0][PW-1:0]    sum_s;
    logic [STAGES-1:0][WIDTH-1:0] mplier_s;

    assign vld_s[0]    = in_valid;
    assign sign_s[0]   = signed_mode & (in_1[WIDTH-1] ^ in_2[WIDTH-1]);
    assign mcand_s[0]  = PW'(magnitude(64'(in_1), WIDTH, signed_mode));
    assign mplier_s[0] = WIDTH'(magnitude(64'(in_2), WIDTH, signed_mode));
    assign sum_s[0]    = '0;
`ifdef PIPELINED_MULTIPLICATION_ACCUMULATE_EN
    assign acc_clr_s[0] = acc_clear;
`else
    assign acc_clr_s[0] = 1'b1;
`endif

    for (genvar i = 0; i < LAST; i++) begin : g_stage
        multiplication_stage #(
            .WIDTH          (WIDTH),
            .BITS_PER_STAGE (BITS_PER_STAGE)
        ) u_stage (
            .clk         (clk),
            .reset       (reset),
            .enable      (enable),
            .in_vld      (vld_s[i]),
            .in_sign     (sign_s[i]),
            .in_acc_clr  (acc_clr_s[i]),
            .in_mcand    (mcand_s[i]),
            .in_sum      (sum_s[i]),
            .in_mplier   (mplier_s[i]),
            .out_vld     (vld_s[i+1]),
            .out_sign    (sign_s[i+1]),
            .out_acc_clr (acc_clr_s[i+1]),
            .out_mcand   (mcand_s[i+1]),
            .out_sum     (sum_s[i+1]),
            .out_mplier  (mplier_s[i+1])
        );
    end

    logic [PW-1:0] prod_raw;
    logic [PW-1:0] prod;
    logic [PW-1:0] out_d, out_q;
    logic          out_valid_d, out_valid_q;

    // The last chunk, sign fix-up and accumulate all fold into the output register.
    always_comb begin
        prod_raw    = sum_s[LAST] + mcand_s[LAST] * PW'(mplier_s[LAST] & CHUNK_MASK);
        prod        = sign_s[LAST] ? (~prod_raw + PW'(1)) : prod_raw;
        out_d       = out_q;
        out_valid_d = vld_s[LAST];
        if (vld_s[LAST]) begin
            out_d = acc_clr_s[LAST] ? prod : (out_q + prod);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (enable) begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_pipelined_multiplication.sv
// Drives three multiplier configurations (6x6/1, 6x6/2, 8x8/1) from one random stream
// and compares each against an arithmetic reference of "result = op from STAGES-1 enabled edges ago".
module tb_pipelined_multiplication;

`ifdef PIPELINED_MULTIPLICATION_ACCUMULATE_EN
    localparam bit ACC = 1'b1;
`else
    localparam bit ACC = 1'b0;
`endif
    localparam int ND = 3;

    typedef struct packed {
        logic       vld;
        logic       sm;
        logic       clr;
        logic [7:0] a;
        logic [7:0] b;
    } op_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        in_valid;
    logic        signed_mode;
    logic        acc_clear;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic [11:0] out1;
    logic [11:0] out2;
    logic [15:0] out3;
    logic        v1, v2, v3;

    logic [15:0] act_out [ND];
    logic        act_vld [ND];
    logic [15:0] exp_out [ND];
    logic        exp_vld [ND];
    op_t         hist [16];
    int          ncap;
    int          n_chk;
    int          n_err;

    always #5 clk = ~clk;

    pipelined_multiplication #(.WIDTH(6), .BITS_PER_STAGE(1)) u_dut1 (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .signed_mode(signed_mode),
`ifdef PIPELINED_MULTIPLICATION_ACCUMULATE_EN
        .acc_clear(acc_clear),
`endif
        .in_1(a8[5:0]), .in_2(b8[5:0]), .out(out1), .out_valid(v1));

    pipelined_multiplication #(.WIDTH(6), .BITS_PER_STAGE(2)) u_dut2 (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .signed_mode(signed_mode),
`ifdef PIPELINED_MULTIPLICATION_ACCUMULATE_EN
        .acc_clear(acc_clear),
`endif
        .in_1(a8[5:0]), .in_2(b8[5:0]), .out(out2), .out_valid(v2));

    pipelined_multiplication #(.WIDTH(8), .BITS_PER_STAGE(1)) u_dut3 (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .signed_mode(signed_mode),
`ifdef PIPELINED_MULTIPLICATION_ACCUMULATE_EN
        .acc_clear(acc_clear),
`endif
        .in_1(a8), .in_2(b8), .out(out3), .out_valid(v3));

    assign act_out[0] = {4'b0, out1};
    assign act_out[1] = {4'b0, out2};
    assign act_out[2] = out3;
    assign act_vld[0] = v1;
    assign act_vld[1] = v2;
    assign act_vld[2] = v3;

    function automatic int stg(input int d);
        case (d)
            0:       return 6;
            1:       return 3;
            default: return 8;
        endcase
    endfunction

    function automatic int wid(input int d);
        return (d == 2) ? 8 : 6;
    endfunction

    function automatic logic [15:0] ref_prod(input op_t o, input int w);
        longint full, av, bv, p;
        full = longint'(1) << w;
        av   = longint'(o.a) % full;
        bv   = longint'(o.b) % full;
        if (o.sm) begin
            if (av >= full / 2) av = av - full;
            if (bv >= full / 2) bv = bv - full;
        end
        p = (av * bv) & (full * full - 1);
        return 16'(p);
    endfunction

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic check_outs();
        for (int d = 0; d < ND; d++) begin
            chk_eq($sformatf("out_valid[%0d]", d), 32'(act_vld[d]), 32'(exp_vld[d]));
            chk_eq($sformatf("out[%0d]", d), 32'(act_out[d]), 32'(exp_out[d]));
        end
    endtask

    task automatic model_reset();
        ncap = 0;
        for (int d = 0; d < ND; d++) begin
            exp_out[d] = '0;
            exp_vld[d] = 1'b0;
        end
    endtask

    task automatic model_edge(input op_t cur);
        op_t         o;
        logic [15:0] p;
        logic [15:0] m;
        hist[ncap % 16] = cur;
        ncap++;
        for (int d = 0; d < ND; d++) begin
            if (ncap >= stg(d)) begin
                o = hist[(ncap - stg(d)) % 16];
                exp_vld[d] = o.vld;
                if (o.vld) begin
                    p = ref_prod(o, wid(d));
                    m = 16'((32'd1 << (2 * wid(d))) - 1);
                    exp_out[d] = (ACC && !o.clr) ? ((exp_out[d] + p) & m) : p;
                end
            end else begin
                exp_vld[d] = 1'b0;
            end
        end
    endtask

    task automatic step(input logic en, input logic vld, input logic sm, input logic clr,
                        input logic [7:0] a, input logic [7:0] b);
        op_t cur;
        enable      = en;
        in_valid    = vld;
        signed_mode = sm;
        acc_clear   = clr;
        a8          = a;
        b8          = b;
        cur = '{vld: vld, sm: sm, clr: clr, a: a, b: b};
        @(posedge clk);
        #1;
        if (en) model_edge(cur);
        check_outs();
    endtask

    task automatic rand_step(input logic en, input logic vld);
        step(en, vld, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
             8'($urandom), 8'($urandom));
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        reset = 1'b1;
        enable = 1'b0;
        in_valid = 1'b0;
        signed_mode = 1'b0;
        acc_clear = 1'b1;
        a8 = '0;
        b8 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outs();
        #2 reset = 1'b0;

        // Directed unsigned then signed corner products (sign-extended to 8 bits).
        step(1, 1, 0, 1, 8'd1,  8'd10);
        step(1, 1, 0, 1, 8'd10, 8'd12);
        step(1, 1, 0, 1, 8'd60, 8'd40);
        step(1, 1, 1, 1, 8'hFD, 8'd5);
        step(1, 1, 1, 1, 8'hE0, 8'hE0);
        step(1, 1, 1, 1, 8'hE0, 8'd31);
        step(1, 1, 1, 1, 8'd31, 8'd31);
        drain(9);

        // Accumulate sequence: products alone when the feature is absent.
        step(1, 1, 0, 1, 8'd3, 8'd4);
        step(1, 1, 0, 0, 8'd5, 8'd6);
        step(1, 1, 0, 0, 8'd2, 8'd2);
        step(1, 1, 0, 1, 8'd7, 8'd1);
        drain(9);

        for (int i = 0; i < 8; i++) rand_step(1'b1, 1'b1);
        for (int i = 0; i < 24; i++) rand_step(1'b1, (i % 3) != 2);

        // Stall mid-stream with garbage on the inputs.
        for (int i = 0; i < 4; i++) rand_step(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) rand_step(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) rand_step(1'b1, 1'b1);
        drain(9);

        // Asynchronous reset with several operations in flight.
        for (int i = 0; i < 6; i++) rand_step(1'b1, 1'b1);
        in_valid = 1'b0;
        #3 reset = 1'b1;
        #1;
        model_reset();
        check_outs();
        @(posedge clk);
        #1;
        check_outs();
        #2 reset = 1'b0;
        drain(10);

        for (int i = 0; i < 30; i++) rand_step(1'b1, ($urandom_range(0, 3) != 0));
        drain(9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
